red_sequencer: RTL and testbench

RED_SEQUENCER -- requirements
Module: red_sequencer

---
 rtl/red_seq_pkg.sv | 23 ++
 rtl/byte_add8.sv | 19 +
 rtl/red_sequencer.sv | 142 ++++++++++++++
 tb/tb_red_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/red_seq_pkg.sv
// Shared definitions for the reduction sequencer: widths, latency and the
// FSM state encoding used by the top level.
package red_seq_pkg;

    localparam int DATA_W  = 16;
    localparam int BYTE_W  = 8;
    localparam int LATENCY = 4;

    // Explicit 3-bit state encoding.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HI   = 3'd1,
        LO   = 3'd2,
        SUM  = 3'd3,
        DONE = 3'd4
    } state_e;

    // Sign-extend a byte-wide value to the full data width.
    function automatic logic [DATA_W-1:0] sext_byte(input logic [BYTE_W-1:0] v);
        return {{(DATA_W-BYTE_W){v[BYTE_W-1]}}, v};
    endfunction

endpackage

// File: rtl/byte_add8.sv
// 8-bit two's-complement adder, wrapping modulo 256, with a signed-overflow
// flag. This is the single arithmetic resource shared by all reduction steps.
module byte_add8
    import red_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] x,
    input  logic [BYTE_W-1:0] y,
    output logic [BYTE_W-1:0] sum,
    output logic              ovf
);

    // Wrapping add; signed overflow when both operands share a sign that the
    // sum does not.
    always_comb begin
        sum = x + y;
        ovf = (x[BYTE_W-1] == y[BYTE_W-1]) && (sum[BYTE_W-1] != x[BYTE_W-1]);
    end

endmodule

// File: rtl/red_sequencer.sv
// Reduction sequencer: adds the high bytes, then the low bytes, then the two
// partial sums, all through one shared 8-bit adder. The byte result is
// sign-extended to 16 bits and reported with the OR of all three signed
// overflow flags. Every output comes straight from a flop.
module red_sequencer
    import red_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              ovf
);

    state_e              state_q,  state_d;
    logic [DATA_W-1:0]   a_q,      a_d;
    logic [DATA_W-1:0]   b_q,      b_d;
    logic [BYTE_W-1:0]   hi_q,     hi_d;
    logic [BYTE_W-1:0]   lo_q,     lo_d;
    logic                hi_ovf_q, hi_ovf_d;
    logic                lo_ovf_q, lo_ovf_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                ovf_q,    ovf_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;

    logic [BYTE_W-1:0]   add_x;
    logic [BYTE_W-1:0]   add_y;
    logic [BYTE_W-1:0]   add_sum;
    logic                add_ovf;

    byte_add8 u_add (
        .x   (add_x),
        .y   (add_y),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // Next-state, operand mux for the shared adder, and register updates.
    always_comb begin
        // NOTE: every signal gets a default before the case, so no path leaves
        // one unassigned and no latch is inferred.
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_ovf_d = hi_ovf_q;
        lo_ovf_d = lo_ovf_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        add_x    = '0;
        add_y    = '0;

        case (state_q)
            IDLE, DONE: begin
                // A new request is only accepted here; requests seen while
                // busy are dropped, not queued.
                if (start) begin
                    state_d = HI;
                    a_d     = a;
                    b_d     = b;
                end else begin
                    state_d = IDLE;
                end
            end
            HI: begin
                add_x    = a_q[DATA_W-1:BYTE_W];
                add_y    = b_q[DATA_W-1:BYTE_W];
                hi_d     = add_sum;
                hi_ovf_d = add_ovf;
                state_d  = LO;
            end
            LO: begin
                add_x    = a_q[BYTE_W-1:0];
                add_y    = b_q[BYTE_W-1:0];
                lo_d     = add_sum;
                lo_ovf_d = add_ovf;
                state_d  = SUM;
            end
            SUM: begin
                add_x    = hi_q;
                add_y    = lo_q;
                result_d = sext_byte(add_sum);
                ovf_d    = hi_ovf_q | lo_ovf_q | add_ovf;
                state_d  = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags are registered from the next state so they line up
        // with the state they describe.
        busy_d = (state_d == HI) || (state_d == LO) || (state_d == SUM);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the operand and partial-sum registers are ordinary flops,
            // so they are cleared here like the control state; a reset drops
            // any operation in flight.
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            hi_ovf_q <= 1'b0;
            lo_ovf_q <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every flop samples the values
            // computed before this edge.
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_ovf_q <= hi_ovf_d;
            lo_ovf_q <= lo_ovf_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_red_sequencer.sv
// Self-checking bench for red_sequencer: directed scenarios plus randomized
// traffic, compared against a transaction-level reference model.
module tb_red_sequencer;
    import red_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    // Reference model state: cycles left before completion, and the values
    // the outputs must show.
    int          remaining   = 0;
    logic [15:0] pend_result = '0;
    logic        pend_ovf    = 1'b0;
    logic        exp_busy    = 1'b0;
    logic        exp_done    = 1'b0;
    logic [15:0] exp_result  = '0;
    logic        exp_ovf     = 1'b0;
    logic        prev_done   = 1'b0;

    always #5 clk = ~clk;

    red_sequencer dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .ovf    (ovf)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Signed value of a byte, as a plain integer.
    function automatic int sval(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // Reduction computed straight from the arithmetic rules.
    task automatic ref_reduce(input logic [15:0] av, input logic [15:0] bv,
                              output logic [15:0] res, output logic ov);
        int ah, al, bh, bl, h, l, s;
        bit o;
        ah = int'(av) / 256; al = int'(av) % 256;
        bh = int'(bv) / 256; bl = int'(bv) % 256;
        h = (ah + bh) % 256;
        l = (al + bl) % 256;
        s = (h + l) % 256;
        o = 0;
        if (sval(ah) + sval(bh) > 127 || sval(ah) + sval(bh) < -128) o = 1;
        if (sval(al) + sval(bl) > 127 || sval(al) + sval(bl) < -128) o = 1;
        if (sval(h) + sval(l) > 127 || sval(h) + sval(l) < -128) o = 1;
        res = (s >= 128) ? (16'hFF00 | 16'(s)) : 16'(s);
        ov  = o;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then
    // compare every output half a cycle later.
    task automatic step(input logic s, input logic r, input logic [15:0] av, input logic [15:0] bv);
        start = s; rst = r; a = av; b = bv;
        @(posedge clk);
        if (r) begin
            remaining  = 0;
            exp_done   = 1'b0;
            exp_result = '0;
            exp_ovf    = 1'b0;
        end else if (remaining > 0) begin
            remaining--;
            exp_done = (remaining == 0);
            if (exp_done) begin
                exp_result = pend_result;
                exp_ovf    = pend_ovf;
            end
        end else begin
            exp_done = 1'b0;
            if (s) begin
                remaining = LATENCY - 1;
                ref_reduce(av, bv, pend_result, pend_ovf);
            end
        end
        exp_busy = (remaining > 0);
        @(negedge clk);
        check("busy",   16'(busy),   16'(exp_busy));
        check("done",   16'(done),   16'(exp_done));
        check("result", result,      exp_result);
        check("ovf",    16'(ovf),    16'(exp_ovf));
        check("busy_and_done", 16'(busy & done), 16'h0);
        check("done_twice",    16'(done & prev_done), 16'h0);
        prev_done = done;
    endtask

    // One request followed by three idle cycles with junk operands, then a
    // direct check of the known answer at the done cycle.
    task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                          input logic [15:0] want_res, input logic want_ovf, input string tag);
        step(1'b1, 1'b0, av, bv);
        for (int i = 0; i < LATENCY - 1; i++)
            step(1'b0, 1'b0, 16'($urandom), 16'($urandom));
        check({tag, "_done"},   16'(done), 16'h1);
        check({tag, "_result"}, result,    want_res);
        check({tag, "_ovf"},    16'(ovf),  16'(want_ovf));
        step(1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    initial begin
        start = 1'b0; rst = 1'b1; a = '0; b = '0;
        @(negedge clk);

        // Reset state.
        step(1'b0, 1'b1, 16'h0, 16'h0);
        step(1'b1, 1'b1, 16'h1234, 16'h5678);
        check("reset_result", result, 16'h0000);
        check("reset_busy",   16'(busy), 16'h0);

        // Known-answer operations.
        run_op(16'h0102, 16'h0304, 16'h000A, 1'b0, "basic");
        run_op(16'h7F00, 16'h0100, 16'hFF80, 1'b1, "hi_ovf");
        run_op(16'hFFFF, 16'hFFFF, 16'hFFFC, 1'b0, "neg");

        // A start while busy is ignored and does not touch the operands.
        step(1'b1, 1'b0, 16'h0102, 16'h0304);
        step(1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
        step(1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
        step(1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
        check("ignored_done",   16'(done), 16'h1);
        check("ignored_result", result,    16'h000A);
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b0, 16'h0, 16'h0);
        check("ignored_single_done", 16'(done), 16'h0);

        // Back-to-back with start held high.
        for (int i = 0; i < 13; i++) begin
            step(1'b1, 1'b0, 16'h0101, 16'h0101);
            if (done) check("b2b_result", result, 16'h0004);
        end
        step(1'b0, 1'b0, 16'h0, 16'h0);
        step(1'b0, 1'b0, 16'h0, 16'h0);

        // Reset while in LO discards the operation; start loses to reset.
        step(1'b1, 1'b0, 16'h0102, 16'h0304);
        step(1'b0, 1'b0, 16'h0, 16'h0);
        step(1'b1, 1'b1, 16'h0102, 16'h0304);
        check("rst_mid_busy",   16'(busy), 16'h0);
        check("rst_mid_result", result,    16'h0000);
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b0, 16'h0, 16'h0);
        check("rst_mid_no_done", 16'(done), 16'h0);
        run_op(16'h0102, 16'h0304, 16'h000A, 1'b0, "after_rst");

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 9) < 4), ($urandom_range(0, 31) == 0),
                 16'($urandom), 16'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
